// File: rtl/ear_input_if.sv
`timescale 1ns/1ps
// PCM capture in from the i2s side, cleaned EAR level and LED status out to the ULA side.
// Pure wiring bundle, no latency.
// No back-pressure: pcm_valid is a strobe and every sample is consumed.
interface ear_input_if;
    logic        pcm_valid;
    logic [15:0] pcm_inl;
    logic [15:0] pcm_inr;
    logic        ear;
    logic        ear_edge;
    logic [7:0]  edge_count;
    logic        activity;

    modport master (
        output pcm_valid, pcm_inl, pcm_inr,
        input  ear, ear_edge, edge_count, activity
    );

    modport slave (
        input  pcm_valid, pcm_inl, pcm_inr,
        output ear, ear_edge, edge_count, activity
    );
endinterface

// File: rtl/ear_input.sv
`timescale 1ns/1ps
// Tape/line-in front end: stereo PCM -> mono -> DC removal -> hysteresis -> glitch filter -> EAR bit.
// Latency: raw settles 2 cycles after the strobe, ear follows GLITCH_CYC cycles later (10 with defaults).
// No back-pressure: a sample may arrive every cycle and each one is processed.
module ear_input #(
    parameter int HYST       = 1024,
    parameter int AVG_SHIFT  = 6,
    parameter int GLITCH_CYC = 8,
    parameter int ACT_CYC    = 3500000
) (
    input  logic       clk,
    input  logic       nreset,
    ear_input_if.slave bus
);
    localparam int ACC_W = 16 + AVG_SHIFT + 1;
    localparam int GW    = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
    localparam int AW    = $clog2(ACT_CYC + 1);

    localparam logic signed [16:0] HYST_P   = 17'(HYST);
    localparam logic signed [16:0] HYST_N   = -HYST_P;
    localparam logic [GW-1:0]      G_LAST   = GW'(GLITCH_CYC - 1);
    localparam logic [AW-1:0]      ACT_LOAD = AW'(ACT_CYC - 1);

    logic signed [16:0]      sum;
    logic signed [15:0]      mono_r;
    logic                    v1;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] dc_full;
    logic signed [16:0]      diff;
    logic                    raw;
    logic [GW-1:0]           gcnt;
    logic                    ear_r;
    logic                    edge_r;
    logic [7:0]              cnt_r;
    logic                    act_r;
    logic [AW-1:0]           acnt;
    logic                    toggle;

    assign sum     = {bus.pcm_inl[15], bus.pcm_inl} + {bus.pcm_inr[15], bus.pcm_inr};
    assign dc_full = acc >>> AVG_SHIFT;
    assign diff    = {mono_r[15], mono_r} - {dc_full[15], dc_full[15:0]};
    assign toggle  = (raw != ear_r) && (gcnt == G_LAST);

    // Stage 1: L/R average; the 17-bit sum halved always fits 16 bits.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v1     <= 1'b0;
            mono_r <= '0;
        end else begin
            v1 <= bus.pcm_valid;
            if (bus.pcm_valid)
                mono_r <= 16'(sum >>> 1);
        end
    end

    // Stage 2: leaky-average DC tracker and hysteresis comparator against the pre-update dc.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc <= '0;
            raw <= 1'b0;
        end else if (v1) begin
            acc <= acc + ACC_W'(mono_r) - dc_full;
            if (!raw && (diff > HYST_P))
                raw <= 1'b1;
            else if (raw && (diff < HYST_N))
                raw <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            gcnt   <= '0;
            ear_r  <= 1'b0;
            edge_r <= 1'b0;
            cnt_r  <= '0;
        end else begin
            edge_r <= toggle;
            if (raw == ear_r) begin
                gcnt <= '0;
            end else if (toggle) begin
                ear_r <= raw;
                gcnt  <= '0;
                cnt_r <= cnt_r + 8'd1;
            end else begin
                gcnt <= gcnt + GW'(1);
            end
        end
    end

    // A toggle always reloads, even on the cycle the countdown would expire.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            act_r <= 1'b0;
            acnt  <= '0;
        end else if (toggle) begin
            act_r <= 1'b1;
            acnt  <= ACT_LOAD;
        end else if (act_r) begin
            if (acnt == '0)
                act_r <= 1'b0;
            else
                acnt <= acnt - AW'(1);
        end
    end

    assign bus.ear        = ear_r;
    assign bus.ear_edge   = edge_r;
    assign bus.edge_count = cnt_r;
    assign bus.activity   = act_r;
endmodule

// File: tb/tb_ear_input.sv
`timescale 1ns/1ps
// Bench for ear_input: default instance scoreboarded on every ear edge, plus
// GLITCH_CYC=1 and ACT_CYC=100 instances sharing the same stimulus.
module tb_ear_input;
    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    ear_input_if bus_a ();
    ear_input_if bus_b ();
    ear_input_if bus_c ();

    assign bus_b.pcm_valid = bus_a.pcm_valid;
    assign bus_b.pcm_inl   = bus_a.pcm_inl;
    assign bus_b.pcm_inr   = bus_a.pcm_inr;
    assign bus_c.pcm_valid = bus_a.pcm_valid;
    assign bus_c.pcm_inl   = bus_a.pcm_inl;
    assign bus_c.pcm_inr   = bus_a.pcm_inr;

    ear_input u_a (.clk(clk), .nreset(nreset), .bus(bus_a));
    ear_input #(.GLITCH_CYC(1)) u_b (.clk(clk), .nreset(nreset), .bus(bus_b));
    ear_input #(.ACT_CYC(100))  u_c (.clk(clk), .nreset(nreset), .bus(bus_c));

    typedef struct {
        int   cyc;
        logic val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Every ear_edge of the default instance must match the oldest expected edge.
    always @(negedge clk) begin
        if (nreset && bus_a.ear_edge) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL edge_unexpected at cycle=%0d ear=%0b, expected no edge", cyc, bus_a.ear);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc || bus_a.ear !== mon_e.val) begin
                    failures++;
                    $display("FAIL edge_timing got cycle=%0d ear=%0b expected cycle=%0d ear=%0b",
                             cyc, bus_a.ear, mon_e.cyc, mon_e.val);
                end
            end
        end
    end

    int   last_edge_c = 0;
    logic act_prev_c  = 1'b0;
    int   act_falls   = 0;

    always @(negedge clk) begin
        if (nreset) begin
            if (bus_c.ear_edge) begin
                last_edge_c = cyc;
                checks++;
                if (bus_c.activity !== 1'b1) begin
                    failures++;
                    $display("FAIL act_set got activity=%0b expected 1 at cycle=%0d", bus_c.activity, cyc);
                end
            end
            if (act_prev_c && !bus_c.activity) begin
                act_falls++;
                checks++;
                if (cyc - last_edge_c !== 100) begin
                    failures++;
                    $display("FAIL act_fall got delay=%0d expected 100", cyc - last_edge_c);
                end
            end
            act_prev_c = bus_c.activity;
        end else begin
            act_prev_c = 1'b0;
        end
    end

    task automatic put(input logic v, input int s);
        @(negedge clk);
        bus_a.pcm_valid = v;
        bus_a.pcm_inl   = 16'(s);
        bus_a.pcm_inr   = 16'(s);
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        bus_a.pcm_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // Square wave starting with the high half; halves from index 'skip' on are expected to toggle ear.
    task automatic square(input int base, input int amp, input int half, input int gap,
                          input int halves, input int skip);
        for (int k = 0; k < halves; k++) begin
            for (int j = 0; j < half; j++) begin
                put(1'b1, (k % 2 == 0) ? base + amp : base - amp);
                if (j == 0 && k >= skip)
                    sb.push_back('{cyc + 10, (k % 2 == 0)});
                if (gap > 1)
                    idle(gap - 1);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        nreset = 1'b0;
        bus_a.pcm_valid = 1'b0;
        bus_a.pcm_inl   = '0;
        bus_a.pcm_inr   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_a.ear, bus_a.ear_edge, bus_a.edge_count, bus_a.activity} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state got ear=%0b edge=%0b count=%0d act=%0b expected all 0",
                     bus_a.ear, bus_a.ear_edge, bus_a.edge_count, bus_a.activity);
        end
        nreset = 1'b1;
        square(0, 8000, 32, 4, 5, 0);
        idle(12);
        checks++;
        if (bus_a.ear !== 1'b1 || bus_a.edge_count !== 8'd5) begin
            failures++;
            $display("FAIL pre_reset got ear=%0b count=%0d expected ear=1 count=5", bus_a.ear, bus_a.edge_count);
        end
        #2 nreset = 1'b0;
        #1;
        checks++;
        if ({bus_a.ear, bus_a.ear_edge, bus_a.edge_count, bus_a.activity} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset got ear=%0b edge=%0b count=%0d act=%0b expected all 0",
                     bus_a.ear, bus_a.ear_edge, bus_a.edge_count, bus_a.activity);
        end
        sb.delete();
        @(negedge clk);
        nreset = 1'b1;
        bad = 0;
        repeat (1000) begin
            put(1'b0, 0);
            if ({bus_a.ear, bus_a.ear_edge, bus_a.edge_count, bus_a.activity} !== 11'd0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_outputs got %0d nonzero cycles expected 0", bad);
        end
    endtask

    task automatic test_square();
        do_reset();
        square(0, 8000, 32, 4, 2, 0);
        checks++;
        if (bus_a.edge_count !== 8'd2) begin
            failures++;
            $display("FAIL square_period got count=%0d expected 2", bus_a.edge_count);
        end
        square(0, 8000, 32, 4, 2, 0);
        idle(12);
        checks++;
        if (bus_a.edge_count !== 8'd4 || sb.size() !== 0) begin
            failures++;
            $display("FAIL square_end got count=%0d pending=%0d expected count=4 pending=0",
                     bus_a.edge_count, sb.size());
        end
    endtask

    task automatic test_subthreshold();
        do_reset();
        square(0, 500, 32, 4, 4, 4);
        idle(12);
        checks++;
        if (bus_a.ear !== 1'b0 || bus_a.edge_count !== 8'd0) begin
            failures++;
            $display("FAIL subthreshold got ear=%0b count=%0d expected ear=0 count=0", bus_a.ear, bus_a.edge_count);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        put(1'b1, 1024);
        idle(20);
        checks++;
        if (bus_a.ear !== 1'b0 || bus_a.edge_count !== 8'd0) begin
            failures++;
            $display("FAIL hyst_equal got ear=%0b count=%0d expected ear=0 count=0", bus_a.ear, bus_a.edge_count);
        end
        do_reset();
        put(1'b1, 1025);
        sb.push_back('{cyc + 10, 1'b1});
        idle(20);
        checks++;
        if (bus_a.ear !== 1'b1 || bus_a.edge_count !== 8'd1 || sb.size() !== 0) begin
            failures++;
            $display("FAIL hyst_above got ear=%0b count=%0d pending=%0d expected ear=1 count=1 pending=0",
                     bus_a.ear, bus_a.edge_count, sb.size());
        end
    endtask

    task automatic test_glitch();
        int   n;
        logic a_edge_seen;
        do_reset();
        put(1'b1, 8000);
        n = cyc;
        put(1'b1, -8000);
        a_edge_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            put(1'b0, 0);
            if (bus_a.ear_edge)
                a_edge_seen = 1'b1;
            if (cyc == n + 3) begin
                checks++;
                if (bus_b.ear !== 1'b1 || bus_b.ear_edge !== 1'b1) begin
                    failures++;
                    $display("FAIL glitch1_rise got ear=%0b edge=%0b expected 1 1", bus_b.ear, bus_b.ear_edge);
                end
            end
            if (cyc == n + 4) begin
                checks++;
                if (bus_b.ear !== 1'b0 || bus_b.ear_edge !== 1'b1) begin
                    failures++;
                    $display("FAIL glitch1_fall got ear=%0b edge=%0b expected 0 1", bus_b.ear, bus_b.ear_edge);
                end
            end
        end
        checks++;
        if (a_edge_seen !== 1'b0 || bus_a.ear !== 1'b0 || bus_a.edge_count !== 8'd0) begin
            failures++;
            $display("FAIL glitch_reject got edge_seen=%0b ear=%0b count=%0d expected 0 0 0",
                     a_edge_seen, bus_a.ear, bus_a.edge_count);
        end
        checks++;
        if (bus_b.edge_count !== 8'd2) begin
            failures++;
            $display("FAIL glitch1_count got count=%0d expected 2", bus_b.edge_count);
        end
    endtask

    task automatic test_dc_activity();
        int falls0;
        do_reset();
        falls0 = act_falls;
        put(1'b1, 10000);
        sb.push_back('{cyc + 10, 1'b1});
        repeat (1999) put(1'b1, 10000);
        square(10000, 3000, 32, 4, 4, 1);
        idle(12);
        checks++;
        if (bus_a.ear !== 1'b0 || bus_a.edge_count !== 8'd4 || sb.size() !== 0) begin
            failures++;
            $display("FAIL dc_track got ear=%0b count=%0d pending=%0d expected ear=0 count=4 pending=0",
                     bus_a.ear, bus_a.edge_count, sb.size());
        end
        checks++;
        if (act_falls - falls0 !== 4) begin
            failures++;
            $display("FAIL act_fall_count got %0d expected 4", act_falls - falls0);
        end
        checks++;
        if (bus_a.activity !== 1'b1 || bus_c.activity !== 1'b0) begin
            failures++;
            $display("FAIL act_levels got default=%0b short=%0b expected 1 0", bus_a.activity, bus_c.activity);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        square(0, 8000, 16, 1, 256, 0);
        idle(12);
        checks++;
        if (bus_a.edge_count !== 8'd0 || bus_a.ear !== 1'b0 || sb.size() !== 0) begin
            failures++;
            $display("FAIL wrap got count=%0d ear=%0b pending=%0d expected count=0 ear=0 pending=0",
                     bus_a.edge_count, bus_a.ear, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_subthreshold();
        test_hysteresis();
        test_glitch();
        test_dc_activity();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
